offchip_mem_model_mc: RTL and testbench

- Parametrised multi-channel off-chip memory model placed between the HLS top (`main`) master ports and the testbench.
- Generalises the fixed 2-channel, 8-bit, 7-bit-address model to N channels, configurable data/address width, and separate read and write latencies.
- Adds a backdoor load port, sticky per-channel error flags for out-of-range access and oe/we collision, and a deterministic same-cycle write-conflict rule.
- Used by generated testbenches. Synthesizable style, so it can also back FPGA-in-the-loop runs.

---
 rtl/mem_model_pkg.sv | 24 ++
 rtl/mem_chan_ctrl.sv | 116 +++++++++++
 rtl/offchip_mem_model_mc.sv | 109 ++++++++++
 tb/tb_offchip_mem_model_mc.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared constants and helpers for the multi-channel off-chip memory model.
// Optional access counters are enabled with MEM_ACCESS_COUNT_EN.
package mem_model_pkg;

    localparam int MEM_DELAY_READ  = 2;
    localparam int MEM_DELAY_WRITE = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // One bit of the write mask for an access of `size` bits.
    function automatic logic size_mask_bit(
        input int size,
        input int bitpos,
        input int dw
    );
        return (size >= dw) || (bitpos < size);
    endfunction

endpackage

// File: rtl/mem_chan_ctrl.sv
// Per-channel control: window check, ready counter, read pipeline, error flags.
// MEM_ACCESS_COUNT_EN adds saturating completed-access counters.
module mem_chan_ctrl
    import mem_model_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 7,
    parameter int MEMSIZE = 32,
    parameter int RD_LAT  = MEM_DELAY_READ,
    parameter int WR_LAT  = MEM_DELAY_WRITE,
    parameter int IW      = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] addr,
    input  logic          oe,
    input  logic          we,
    input  logic [DW-1:0] lookup,
    output logic [IW-1:0] idx,
    output logic          wr_en,
    output logic [DW-1:0] rdata,
    output logic          rdy,
    output logic          err_range,
    output logic          err_collision
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count
`endif
);

    localparam int MAXL = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW   = clog2(MAXL) + 1;

    logic          oe_k;
    logic          we_k;
    logic          in_range;
    logic          rd_en;
    logic          rd_done;
    logic          wr_done;
    logic [AW:0]   lo;
    logic [AW:0]   hi;
    logic [CW-1:0] cnt;
    logic [DW-1:0] look;

    // X on an enable must behave like 0
    assign oe_k = (oe === 1'b1);
    assign we_k = (we === 1'b1);

    assign lo       = {1'b0, base_addr};
    assign hi       = lo + (AW+1)'(MEMSIZE);
    assign in_range = ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    assign idx      = IW'(addr - base_addr);

    assign rd_en   = oe_k && !we_k && in_range;
    assign wr_en   = we_k && !oe_k && in_range;
    assign rd_done = rd_en && (cnt == CW'(RD_LAT - 1));
    assign wr_done = wr_en && (cnt == CW'(WR_LAT - 1));
    assign rdy     = !reset && (rd_done || wr_done);
    assign look    = rd_en ? lookup : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rd_en) begin
            cnt <= (int'(cnt) + 1 < RD_LAT) ? cnt + CW'(1) : '0;
        end else if (wr_en) begin
            cnt <= (int'(cnt) + 1 < WR_LAT) ? cnt + CW'(1) : '0;
        end else begin
            cnt <= '0;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_comb
            assign rdata = reset ? '0 : look;
        end else begin : g_pipe
            logic [DW-1:0] pipe [RD_LAT-1];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < RD_LAT - 1; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= look;
                    for (int k = 1; k < RD_LAT - 1; k++) pipe[k] <= pipe[k-1];
                end
            end

            assign rdata = reset ? '0 : pipe[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_range     <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            if ((oe_k || we_k) && !in_range) err_range <= 1'b1;
            if (oe_k && we_k) err_collision <= 1'b1;
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done && rd_count != '1) rd_count <= rd_count + 32'd1;
            if (wr_done && wr_count != '1) wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: rtl/offchip_mem_model_mc.sv
// N-channel off-chip memory model: word array, backdoor load, write arbitration.
// Define MEM_ACCESS_COUNT_EN to expose rd_count/wr_count.
module offchip_mem_model_mc
    import mem_model_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DW      = 8,
    parameter int AW      = 7,
    parameter int SW      = 4,
    parameter int MEMSIZE = 32,
    parameter int RD_LAT  = MEM_DELAY_READ,
    parameter int WR_LAT  = MEM_DELAY_WRITE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [AW-1:0]      base_addr,
    input  logic [N_CH-1:0]    Mout_oe_ram,
    input  logic [N_CH-1:0]    Mout_we_ram,
    input  logic [N_CH*AW-1:0] Mout_addr_ram,
    input  logic [N_CH*DW-1:0] Mout_Wdata_ram,
    input  logic [N_CH*SW-1:0] Mout_data_ram_size,
    input  logic [N_CH*DW-1:0] Sout_Rdata_ram,
    input  logic [N_CH-1:0]    Sout_DataRdy,
    input  logic               init_we,
    input  logic [AW-1:0]      init_addr,
    input  logic [DW-1:0]      init_data,
    output logic [N_CH*DW-1:0] M_Rdata_ram,
    output logic [N_CH-1:0]    M_DataRdy,
    output logic [N_CH-1:0]    err_range,
    output logic [N_CH-1:0]    err_collision
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [N_CH*32-1:0] rd_count,
    output logic [N_CH*32-1:0] wr_count
`endif
);

    localparam int IW = (clog2(MEMSIZE) < 1) ? 1 : clog2(MEMSIZE);

    logic [DW-1:0]      mem [MEMSIZE];
    logic [N_CH*IW-1:0] idx_flat;
    logic [N_CH*DW-1:0] wval_flat;
    logic [N_CH-1:0]    wr_en;
    logic               init_k;

    assign init_k = (init_we === 1'b1) && (int'(init_addr) < MEMSIZE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [IW-1:0] idx;
        logic [DW-1:0] mask;
        logic [DW-1:0] lookup;
        logic [DW-1:0] rdata;
        logic [SW-1:0] size;
        logic          rdy;

        assign size   = Mout_data_ram_size[i*SW +: SW];
        assign lookup = mem[idx];

        always_comb begin
            mask = '0;
            for (int b = 0; b < DW; b++) mask[b] = size_mask_bit(int'(size), b, DW);
        end

        assign idx_flat[i*IW +: IW]  = idx;
        assign wval_flat[i*DW +: DW] = (Mout_Wdata_ram[i*DW +: DW] & mask)
                                     | (lookup & ~mask);

        mem_chan_ctrl #(
            .DW      (DW),
            .AW      (AW),
            .MEMSIZE (MEMSIZE),
            .RD_LAT  (RD_LAT),
            .WR_LAT  (WR_LAT),
            .IW      (IW)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .base_addr     (base_addr),
            .addr          (Mout_addr_ram[i*AW +: AW]),
            .oe            (Mout_oe_ram[i]),
            .we            (Mout_we_ram[i]),
            .lookup        (lookup),
            .idx           (idx),
            .wr_en         (wr_en[i]),
            .rdata         (rdata),
            .rdy           (rdy),
            .err_range     (err_range[i]),
            .err_collision (err_collision[i])
`ifdef MEM_ACCESS_COUNT_EN
            ,
            .rd_count      (rd_count[i*32 +: 32]),
            .wr_count      (wr_count[i*32 +: 32])
`endif
        );

        assign M_Rdata_ram[i*DW +: DW] = reset ? '0
                                       : (rdata | Sout_Rdata_ram[i*DW +: DW]);
        assign M_DataRdy[i] = !reset && (rdy || Sout_DataRdy[i]);
    end

    // Later channels are assigned last, so the highest index wins a shared word
    always_ff @(posedge clock) begin
        if (init_k) mem[IW'(init_addr)] <= init_data;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en[i]) mem[idx_flat[i*IW +: IW]] <= wval_flat[i*DW +: DW];
        end
    end

endmodule

// File: tb/tb_offchip_mem_model_mc.sv
// Scoreboard bench: a per-cycle reference model pushes expectations, a monitor checks.
`timescale 1ns/1ps
module tb_offchip_mem_model_mc;

    localparam int NC = 2;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int SW = 4;
    localparam int MS = 32;
    localparam int RL = 2;
    localparam int WL = 1;
    localparam int HD = (RL > 1) ? RL - 1 : 1;

    logic             clock;
    logic             reset;
    logic [AW-1:0]    base_addr;
    logic [NC-1:0]    oe;
    logic [NC-1:0]    we;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC*SW-1:0] size;
    logic [NC*DW-1:0] s_rdata;
    logic [NC-1:0]    s_rdy;
    logic             init_we;
    logic [AW-1:0]    init_addr;
    logic [DW-1:0]    init_data;
    logic [NC*DW-1:0] rdata;
    logic [NC-1:0]    rdy;
    logic [NC-1:0]    err_range;
    logic [NC-1:0]    err_collision;
`ifdef MEM_ACCESS_COUNT_EN
    logic [NC*32-1:0] rd_count;
    logic [NC*32-1:0] wr_count;
`endif

    offchip_mem_model_mc #(
        .N_CH(NC), .DW(DW), .AW(AW), .SW(SW),
        .MEMSIZE(MS), .RD_LAT(RL), .WR_LAT(WL)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .base_addr          (base_addr),
        .Mout_oe_ram        (oe),
        .Mout_we_ram        (we),
        .Mout_addr_ram      (addr),
        .Mout_Wdata_ram     (wdata),
        .Mout_data_ram_size (size),
        .Sout_Rdata_ram     (s_rdata),
        .Sout_DataRdy       (s_rdy),
        .init_we            (init_we),
        .init_addr          (init_addr),
        .init_data          (init_data),
        .M_Rdata_ram        (rdata),
        .M_DataRdy          (rdy),
        .err_range          (err_range),
        .err_collision      (err_collision)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .rd_count           (rd_count),
        .wr_count           (wr_count)
`endif
    );

    typedef struct packed {
        logic [NC-1:0]    rdy;
        logic [NC*DW-1:0] rdata;
        logic [NC-1:0]    erng;
        logic [NC-1:0]    ecol;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] mem_m [MS];
    int            cnt_m [NC];
    logic [DW-1:0] hist [NC][HD];
    logic [NC-1:0] erng_m;
    logic [NC-1:0] ecol_m;
    int            nvec = 0;
    int            nerr = 0;

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    function automatic bit in_rng(input int a);
        return a >= int'(base_addr) && a < int'(base_addr) + MS;
    endfunction

    function automatic logic [DW-1:0] mask_of(input int sz);
        int mi;
        mi = (sz >= DW) ? (1 << DW) - 1 : (1 << sz) - 1;
        return mi[DW-1:0];
    endfunction

    // One clock cycle: predict this cycle's outputs, then apply the edge.
    task automatic step();
        exp_t          e;
        logic [DW-1:0] look [NC];
        logic [DW-1:0] old [MS];
        bit            rd [NC];
        bit            wr [NC];
        int            a;
        int            off;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            a = int'(addr[c*AW +: AW]);
            rd[c] = oe[c] && !we[c] && in_rng(a);
            wr[c] = we[c] && !oe[c] && in_rng(a);
            look[c] = rd[c] ? mem_m[a - int'(base_addr)] : '0;
            e.rdy[c] = s_rdy[c] | ((rd[c] && cnt_m[c] == RL - 1)
                                 || (wr[c] && cnt_m[c] == WL - 1));
            e.rdata[c*DW +: DW] = s_rdata[c*DW +: DW]
                                | ((RL == 1) ? look[c] : hist[c][HD-1]);
        end
        e.erng = erng_m;
        e.ecol = ecol_m;
        if (reset) e = '0;
        sb.push_back(e);
        @(posedge clock);
        old = mem_m;
        if (init_we && int'(init_addr) < MS) mem_m[int'(init_addr)] = init_data;
        for (int c = 0; c < NC; c++) begin
            if (wr[c]) begin
                off = int'(addr[c*AW +: AW]) - int'(base_addr);
                mem_m[off] = (wdata[c*DW +: DW] & mask_of(int'(size[c*SW +: SW])))
                           | (old[off] & ~mask_of(int'(size[c*SW +: SW])));
            end
        end
        for (int c = 0; c < NC; c++) begin
            a = int'(addr[c*AW +: AW]);
            if (reset) begin
                cnt_m[c] = 0;
                for (int k = 0; k < HD; k++) hist[c][k] = '0;
                erng_m[c] = 1'b0;
                ecol_m[c] = 1'b0;
            end else begin
                if (rd[c]) cnt_m[c] = (cnt_m[c] < RL - 1) ? cnt_m[c] + 1 : 0;
                else if (wr[c]) cnt_m[c] = (cnt_m[c] < WL - 1) ? cnt_m[c] + 1 : 0;
                else cnt_m[c] = 0;
                for (int k = HD - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = look[c];
                if ((oe[c] || we[c]) && !in_rng(a)) erng_m[c] = 1'b1;
                if (oe[c] && we[c]) ecol_m[c] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        oe = '0;
        we = '0;
        init_we = 1'b0;
    endtask

    task automatic req(input int c, input bit o, input bit w,
                       input int a, input int d, input int sz);
        oe[c] = o;
        we[c] = w;
        addr[c*AW +: AW] = a[AW-1:0];
        wdata[c*DW +: DW] = d[DW-1:0];
        size[c*SW +: SW] = sz[SW-1:0];
    endtask

    task automatic load(input int i, input int d);
        init_we = 1'b1;
        init_addr = i[AW-1:0];
        init_data = d[DW-1:0];
        step();
        init_we = 1'b0;
    endtask

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL scoreboard at %0t: got empty queue expected entry", $time);
            end else begin
                e = sb.pop_front();
                check("data_rdy", 64'(rdy), 64'(e.rdy));
                check("rdata", 64'(rdata), 64'(e.rdata));
                check("err_range", 64'(err_range), 64'(e.erng));
                check("err_collision", 64'(err_collision), 64'(e.ecol));
            end
        end
    end

    task automatic random_phase(input int cycles, input bit use_slave);
        int r;
        int a;
        for (int n = 0; n < cycles; n++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 9) >= 4) begin
                    r = $urandom_range(0, 19);
                    a = int'(base_addr) - 4 + $urandom_range(0, MS + 7);
                    req(c, (r < 7) || (r == 19), (r >= 7 && r < 14) || (r == 19),
                        a, $urandom, $urandom_range(0, 15));
                end
            end
            init_we = (we == '0) && ($urandom_range(0, 7) == 0);
            init_addr = AW'($urandom_range(0, MS + 3));
            init_data = DW'($urandom);
            if (use_slave && $urandom_range(0, 7) == 0) begin
                s_rdy = NC'($urandom);
                s_rdata = (NC*DW)'($urandom);
            end else begin
                s_rdy = '0;
                s_rdata = '0;
            end
            step();
        end
        idle();
        s_rdy = '0;
        s_rdata = '0;
    endtask

    initial begin
        #2;
        reset = 1'b1;
        base_addr = 7'h10;
        oe = '0;
        we = '0;
        addr = '0;
        wdata = '0;
        size = '0;
        s_rdata = '0;
        s_rdy = '0;
        init_we = 1'b0;
        init_addr = '0;
        init_data = '0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < MS; i++) load(i, $urandom);

        req(0, 0, 1, 'h12, 'hA5, 8);
        step();
        req(0, 1, 0, 'h12, 0, 8);
        step();
        step();
        idle();
        step();

        load(2, 'hFF);
        req(1, 0, 1, 'h12, 'h00, 4);
        step();
        idle();
        req(0, 1, 0, 'h12, 0, 8);
        step();
        step();
        idle();
        step();

        req(0, 0, 1, 'h13, 'h11, 8);
        req(1, 0, 1, 'h13, 'h22, 8);
        step();
        idle();
        req(0, 1, 0, 'h13, 0, 8);
        step();
        step();
        idle();
        step();

        req(0, 1, 0, 'h05, 0, 8);
        step();
        step();
        idle();
        step();
        step();

        req(1, 1, 1, 'h13, 'h77, 8);
        step();
        idle();
        req(1, 1, 0, 'h13, 0, 8);
        step();
        step();
        idle();
        step();

        load(5, 'h3C);
        req(0, 1, 0, 'h15, 0, 8);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req(0, 1, 0, 'h15, 0, 8);
        step();
        step();
        idle();
        step();

        random_phase(300, 1'b0);
        base_addr = 7'h60;
        random_phase(300, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        random_phase(100, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
